// File: rtl/coin_return_sequencer_pkg.sv
// Shared definitions for the change-return path.
//   - Bus widths and default idle timeout.
//   - Coin denominations (index 0 = smallest).
//   - FSM state encodings for the return sequencer.
//   - coin_value(): denomination lookup, zero-extended to the balance width.
package coin_return_sequencer_pkg;

    localparam int unsigned NUM_COINS  = 3;
    localparam int unsigned TOTAL_BITS = 31;
    localparam int unsigned WAIT_TIME  = 100;

    localparam int unsigned COIN_VAL0 = 100;
    localparam int unsigned COIN_VAL1 = 500;
    localparam int unsigned COIN_VAL2 = 1000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic [TOTAL_BITS-1:0] coin_value(input int unsigned idx);
        logic [TOTAL_BITS-1:0] val;
        case (idx)
            0:       val = TOTAL_BITS'(COIN_VAL0);
            1:       val = TOTAL_BITS'(COIN_VAL1);
            2:       val = TOTAL_BITS'(COIN_VAL2);
            default: val = '0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/coin_return_sequencer_greedy_select.sv
// coin_greedy_select: combinational largest-coin picker.
//   residual : remaining amount to pay
//   coin     : one-hot of the largest denomination not exceeding residual
//   value    : that denomination's value (zero when none fits)
//   found    : a denomination fits
module coin_greedy_select
    import coin_return_sequencer_pkg::*;
(
    input  logic [TOTAL_BITS-1:0] residual,
    output logic [NUM_COINS-1:0]  coin,
    output logic [TOTAL_BITS-1:0] value,
    output logic                  found
);

    // Ascending scan; the last fitting denomination is the largest one.
    always_comb begin
        coin  = '0;
        value = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_COINS; k++) begin
            if (coin_value(k) <= residual) begin
                coin    = '0;
                coin[k] = 1'b1;
                value   = coin_value(k);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coin_return_sequencer.sv
// coin_return_sequencer: change-return controller.
// Owns the inactivity timer, starts a return on user request or timeout, and
// pays the latched balance to the hopper largest coin first, one per cycle.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_input_coin      one-hot coin insertion strobe (reloads the idle timer)
//   i_item_dispensed  item output this cycle (reloads the idle timer)
//   i_trigger_return  user return request
//   i_total           balance from the datapath, sampled when a return starts
//   i_hopper_ready    hopper accepts the offered coin
//   o_return_coin     one-hot coin on offer, zero when not valid
//   o_coin_valid      coin offered to the hopper
//   o_deduct_en       pulse per accepted coin
//   o_deduct          value of the accepted coin, zero otherwise
//   o_busy            return in progress
//   o_done            pulse in the final cycle of a return
//   o_residual        unpayable remainder of the last return
//   o_wait_time       remaining idle cycles before an automatic return
module coin_return_sequencer
    import coin_return_sequencer_pkg::*;
#(
    parameter int unsigned WAIT_TIME = coin_return_sequencer_pkg::WAIT_TIME
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_COINS-1:0]  i_input_coin,
    input  logic                  i_item_dispensed,
    input  logic                  i_trigger_return,
    input  logic [TOTAL_BITS-1:0] i_total,
    input  logic                  i_hopper_ready,
    output logic [NUM_COINS-1:0]  o_return_coin,
    output logic                  o_coin_valid,
    output logic                  o_deduct_en,
    output logic [TOTAL_BITS-1:0] o_deduct,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [TOTAL_BITS-1:0] o_residual,
    output logic [31:0]           o_wait_time
);

    localparam logic [31:0] WAIT_RELOAD = 32'(WAIT_TIME);

    logic [1:0]            state_q, state_d;
    logic [TOTAL_BITS-1:0] residual_q, residual_d;
    logic [TOTAL_BITS-1:0] resid_out_q, resid_out_d;
    logic [31:0]           wait_q, wait_d;

    logic [NUM_COINS-1:0]  sel_coin;
    logic [TOTAL_BITS-1:0] sel_value;
    logic                  sel_found;
    logic [TOTAL_BITS-1:0] residual_next;
    logic                  accept;

    coin_greedy_select u_select (
        .residual (residual_q),
        .coin     (sel_coin),
        .value    (sel_value),
        .found    (sel_found)
    );

    // Cannot underflow: the selected value never exceeds the residual.
    assign residual_next = residual_q - sel_value;

    assign o_coin_valid  = (state_q == ST_ISSUE) && sel_found;
    assign accept        = o_coin_valid && i_hopper_ready;
    assign o_return_coin = o_coin_valid ? sel_coin : '0;
    assign o_deduct_en   = accept;
    assign o_deduct      = accept ? sel_value : '0;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_done        = (state_q == ST_DONE);
    assign o_residual    = resid_out_q;
    assign o_wait_time   = wait_q;

    always_comb begin
        state_d     = state_q;
        residual_d  = residual_q;
        resid_out_d = resid_out_q;
        wait_d      = wait_q;
        case (state_q)
            ST_IDLE: begin
                // Activity wins over a same-cycle trigger.
                if ((|i_input_coin) || i_item_dispensed) begin
                    wait_d = WAIT_RELOAD;
                end else if (i_trigger_return || (wait_q == 32'd0)) begin
                    if (i_total != '0) begin
                        residual_d  = i_total;
                        resid_out_d = '0;
                        state_d     = ST_ISSUE;
                    end else begin
                        wait_d = 32'd0;
                    end
                end else begin
                    wait_d = wait_q - 32'd1;
                end
            end
            ST_ISSUE: begin
                if (!sel_found) begin
                    state_d     = ST_DONE;
                    resid_out_d = residual_q;
                end else if (accept) begin
                    residual_d = residual_next;
                    // Finish straight after the last payable coin so DONE
                    // follows it without an empty ISSUE cycle.
                    if (residual_next < coin_value(0)) begin
                        state_d     = ST_DONE;
                        resid_out_d = residual_next;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                wait_d  = WAIT_RELOAD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            residual_q  <= '0;
            resid_out_q <= '0;
            wait_q      <= WAIT_RELOAD;
        end else begin
            state_q     <= state_d;
            residual_q  <= residual_d;
            resid_out_q <= resid_out_d;
            wait_q      <= wait_d;
        end
    end

endmodule

// File: tb/tb_coin_return_sequencer.sv
// Self-checking bench for coin_return_sequencer (idle timeout shortened to 5).
module tb_coin_return_sequencer;

    localparam int unsigned WT = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  i_input_coin;
    logic        i_item_dispensed;
    logic        i_trigger_return;
    logic [30:0] i_total;
    logic        i_hopper_ready;
    logic [2:0]  o_return_coin;
    logic        o_coin_valid;
    logic        o_deduct_en;
    logic [30:0] o_deduct;
    logic        o_busy;
    logic        o_done;
    logic [30:0] o_residual;
    logic [31:0] o_wait_time;

    coin_return_sequencer #(.WAIT_TIME(WT)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_input_coin     (i_input_coin),
        .i_item_dispensed (i_item_dispensed),
        .i_trigger_return (i_trigger_return),
        .i_total          (i_total),
        .i_hopper_ready   (i_hopper_ready),
        .o_return_coin    (o_return_coin),
        .o_coin_valid     (o_coin_valid),
        .o_deduct_en      (o_deduct_en),
        .o_deduct         (o_deduct),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_residual       (o_residual),
        .o_wait_time      (o_wait_time)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  coin;
        logic [30:0] value;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          errors  = 0;
    int unsigned denom[3] = '{100, 500, 1000};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Greedy reference: pushes expected coins, returns remainder and count.
    task automatic push_model(input logic [30:0] total, output logic [30:0] rem,
                              output int ncoins);
        rem    = total;
        ncoins = 0;
        for (int k = 2; k >= 0; k--) begin
            while (rem >= 31'(denom[k])) begin
                exp_t e;
                e.coin  = 3'b001 << k;
                e.value = 31'(denom[k]);
                sb.push_back(e);
                rem = rem - 31'(denom[k]);
                ncoins++;
            end
        end
    endtask

    task automatic check_pop(input string name);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected deduct %0d coin %b, scoreboard empty",
                     name, o_deduct, o_return_coin);
        end else begin
            e = sb.pop_front();
            if (o_return_coin !== e.coin || o_deduct !== e.value || o_coin_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s: got coin %b deduct %0d valid %b, want coin %b deduct %0d valid 1",
                         name, o_return_coin, o_deduct, o_coin_valid, e.coin, e.value);
            end
        end
    endtask

    task automatic apply_reset();
        reset            = 1'b1;
        i_input_coin     = '0;
        i_item_dispensed = 1'b0;
        i_trigger_return = 1'b0;
        i_total          = '0;
        i_hopper_ready   = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        settle();
        vectors++;
        if (o_busy !== 1'b0 || o_coin_valid !== 1'b0 || o_deduct_en !== 1'b0 ||
            o_done !== 1'b0 || o_residual !== 31'd0 || o_wait_time !== 32'(WT) ||
            o_return_coin !== 3'b000 || o_deduct !== 31'd0) begin
            errors++;
            $display("FAIL reset: busy %b valid %b den %b done %b resid %0d wait %0d, want 0 0 0 0 0 %0d",
                     o_busy, o_coin_valid, o_deduct_en, o_done, o_residual, o_wait_time, WT);
        end
        step();
    endtask

    // Reload the timer, trigger with the given balance, then follow the payout.
    task automatic run_payout(input logic [30:0] total, input string name,
                              output logic [31:0] sum);
        logic [30:0] rem;
        int          ncoins;
        int          cyc;
        bit          done;
        i_item_dispensed = 1'b1;
        step();
        i_item_dispensed = 1'b0;
        i_trigger_return = 1'b1;
        i_total          = total;
        push_model(total, rem, ncoins);
        settle();
        vectors++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: busy %b, want 0", name, o_busy);
        end
        step();
        i_trigger_return = 1'b0;
        cyc  = 1;
        done = 1'b0;
        sum  = 0;
        while (!done && cyc <= 20) begin
            settle();
            if (cyc == 1) begin
                vectors++;
                if (o_coin_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL %s latency: valid %b in first cycle, want 1", name, o_coin_valid);
                end
            end
            if (o_deduct_en === 1'b1) begin
                check_pop(name);
                sum = sum + 32'(o_deduct);
            end
            if (o_done === 1'b1) begin
                done = 1'b1;
                vectors++;
                if (cyc != ncoins + 1 || o_residual !== rem || sb.size() != 0 || o_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s done: cycle %0d resid %0d left %0d busy %b, want cycle %0d resid %0d left 0 busy 1",
                             name, cyc, o_residual, sb.size(), o_busy, ncoins + 1, rem);
                end
            end
            step();
            cyc++;
        end
        if (!done) begin
            vectors++;
            errors++;
            $display("FAIL %s timeout: no done within 20 cycles, want done", name);
        end
        sb.delete();
    endtask

    task automatic test_payout_1600();
        logic [31:0] sum;
        run_payout(31'd1600, "payout_1600", sum);
    endtask

    task automatic test_back_to_back();
        logic [31:0] sum;
        run_payout(31'd2700, "payout_2700", sum);
        vectors++;
        if (sum !== 32'd2700) begin
            errors++;
            $display("FAIL payout_2700 sum: got %0d, want 2700", sum);
        end
    endtask

    task automatic test_stall();
        logic [30:0] rem;
        int          ncoins;
        i_hopper_ready   = 1'b0;
        i_item_dispensed = 1'b1;
        step();
        i_item_dispensed = 1'b0;
        i_trigger_return = 1'b1;
        i_total          = 31'd500;
        push_model(31'd500, rem, ncoins);
        step();
        i_trigger_return = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            settle();
            vectors++;
            if (o_coin_valid !== 1'b1 || o_return_coin !== 3'b010 || o_deduct_en !== 1'b0) begin
                errors++;
                $display("FAIL stall cycle %0d: valid %b coin %b den %b, want 1 010 0",
                         i, o_coin_valid, o_return_coin, o_deduct_en);
            end
            step();
        end
        i_hopper_ready = 1'b1;
        settle();
        if (o_deduct_en === 1'b1) begin
            check_pop("stall_accept");
        end else begin
            vectors++;
            errors++;
            $display("FAIL stall_accept: deduct_en %b, want 1", o_deduct_en);
        end
        step();
        settle();
        vectors++;
        if (o_done !== 1'b1 || o_residual !== rem) begin
            errors++;
            $display("FAIL stall_done: done %b resid %0d, want 1 %0d", o_done, o_residual, rem);
        end
        step();
        sb.delete();
    endtask

    task automatic test_timeout();
        logic [30:0] rem;
        int          ncoins;
        i_input_coin = 3'b001;
        i_total      = 31'd500;
        push_model(31'd500, rem, ncoins);
        step();
        i_input_coin = 3'b000;
        for (int w = WT; w >= 0; w--) begin
            settle();
            vectors++;
            if (o_wait_time !== 32'(w) || o_coin_valid !== 1'b0) begin
                errors++;
                $display("FAIL timeout_count: wait %0d valid %b, want %0d 0", o_wait_time, o_coin_valid, w);
            end
            step();
        end
        settle();
        if (o_deduct_en === 1'b1) begin
            check_pop("timeout_coin");
        end else begin
            vectors++;
            errors++;
            $display("FAIL timeout_coin: valid %b den %b, want 1 1", o_coin_valid, o_deduct_en);
        end
        step();
        settle();
        vectors++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("FAIL timeout_done: done %b, want 1", o_done);
        end
        step();
        i_total = '0;
        sb.delete();
    endtask

    task automatic test_residual();
        logic [31:0] sum;
        run_payout(31'd150, "residual_150", sum);
        i_item_dispensed = 1'b1;
        step();
        i_item_dispensed = 1'b0;
        i_trigger_return = 1'b1;
        i_total          = 31'd0;
        step();
        i_trigger_return = 1'b0;
        settle();
        vectors++;
        if (o_coin_valid !== 1'b0 || o_busy !== 1'b0 || o_wait_time !== 32'd0 ||
            o_residual !== 31'd50) begin
            errors++;
            $display("FAIL zero_total: valid %b busy %b wait %0d resid %0d, want 0 0 0 50",
                     o_coin_valid, o_busy, o_wait_time, o_residual);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [30:0] rem;
        int          ncoins;
        i_item_dispensed = 1'b1;
        step();
        i_item_dispensed = 1'b0;
        i_trigger_return = 1'b1;
        i_total          = 31'd2700;
        push_model(31'd2700, rem, ncoins);
        step();
        i_trigger_return = 1'b0;
        settle();
        check_pop("midreset_first");
        step();
        reset = 1'b1;
        step();
        reset   = 1'b0;
        i_total = '0;
        settle();
        vectors++;
        if (o_busy !== 1'b0 || o_coin_valid !== 1'b0 || o_done !== 1'b0 ||
            o_deduct_en !== 1'b0 || o_wait_time !== 32'(WT)) begin
            errors++;
            $display("FAIL midreset: busy %b valid %b done %b den %b wait %0d, want 0 0 0 0 %0d",
                     o_busy, o_coin_valid, o_done, o_deduct_en, o_wait_time, WT);
        end
        step();
        sb.delete();
    endtask

    task automatic test_coin_and_trigger();
        // Let the timer drain first so the reload is visible.
        for (int i = 0; i < WT + 1; i++) step();
        i_input_coin     = 3'b010;
        i_trigger_return = 1'b1;
        i_total          = 31'd1000;
        step();
        i_input_coin     = 3'b000;
        i_trigger_return = 1'b0;
        i_total          = '0;
        settle();
        vectors++;
        if (o_wait_time !== 32'(WT) || o_busy !== 1'b0 || o_coin_valid !== 1'b0) begin
            errors++;
            $display("FAIL coin_trigger: wait %0d busy %b valid %b, want %0d 0 0",
                     o_wait_time, o_busy, o_coin_valid, WT);
        end
        step();
        settle();
        vectors++;
        if (o_coin_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL coin_trigger_after: valid %b busy %b, want 0 0", o_coin_valid, o_busy);
        end
        step();
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_payout_1600();
        test_back_to_back();
        test_stall();
        test_timeout();
        test_residual();
        test_reset_mid();
        test_coin_and_trigger();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/coin_return_sequencer.md
Name: coin_return_sequencer

Overview:
- Controls the vending machine's change-return path.
- Owns the inactivity wait timer and decides when a return starts: on explicit trigger or on timeout.
- Pays out the latched balance one coin at a time, largest first, to a coin hopper over a valid/ready handshake. A coin value may repeat.
- Tells the balance datapath how much to deduct per coin and blocks new transactions while paying out.

Parameters:
- NUM_COINS, 3, number of coin denominations (index 0 = smallest).
- TOTAL_BITS, 31, width of the balance.
- WAIT_TIME, 100, idle cycles before automatic return.
- COIN_VAL0, 100, value of coin 0.
- COIN_VAL1, 500, value of coin 1.
- COIN_VAL2, 1000, value of coin 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- i_input_coin  in  NUM_COINS  one-hot coin insertion strobe.
- i_item_dispensed  in  1  item was output this cycle.
- i_trigger_return  in  1  user return request.
- i_total  in  TOTAL_BITS  current balance from the datapath.
- i_hopper_ready  in  1  hopper can accept a coin.
- o_return_coin  out  NUM_COINS  one-hot coin being paid; zero when o_coin_valid=0.
- o_coin_valid  out  1  coin offered to the hopper.
- o_deduct_en  out  1  one-cycle pulse per accepted coin.
- o_deduct  out  TOTAL_BITS  value of the accepted coin; zero when o_deduct_en=0.
- o_busy  out  1  return in progress; upstream rejects coins and item selection.
- o_done  out  1  one-cycle pulse when the return sequence ends.
- o_residual  out  TOTAL_BITS  unpayable remainder, held from DONE until the next return starts.
- o_wait_time  out  32  remaining idle cycles.

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE, residual register=0, o_wait_time=WAIT_TIME, o_residual=0.
  - All valid/strobe outputs 0.
  - Reset overrides everything, including mid-sequence. No deduct pulse is issued for an unaccepted coin.
- IDLE, priority order per edge:
  1. i_input_coin!=0 or i_item_dispensed: o_wait_time<=WAIT_TIME. A trigger in the same cycle is dropped.
  2. Else if i_trigger_return=1 or o_wait_time==0:
     - i_total>0: latch residual<=i_total, go to ISSUE.
     - i_total==0: o_wait_time<=0 and stay in IDLE.
  3. Else if o_wait_time>0: decrement it. It saturates at 0.
- ISSUE:
  - o_busy=1.
  - Selected coin = highest index k with COIN_VALk <= residual. This is combinational from the registered residual.
  - If a coin is selected: o_coin_valid=1 and o_return_coin=onehot(k).
  - Transfer happens on an edge with o_coin_valid && i_hopper_ready:
    - residual <= residual - COIN_VALk.
    - o_deduct_en=1 and o_deduct=COIN_VALk in that same cycle.
  - At most one coin per cycle. The next coin is offered the following cycle.
  - While ready=0, valid and o_return_coin stay stable. Valid is never withdrawn until accepted.
  - If no coin fits (residual < COIN_VAL0): o_coin_valid=0; next state DONE with o_residual<=residual.
  - i_input_coin, i_item_dispensed and i_trigger_return are ignored in ISSUE. o_wait_time holds.
- DONE:
  - Lasts one cycle: o_done=1, o_busy=1.
  - Then IDLE with o_wait_time<=WAIT_TIME.
- Latency:
  - Trigger sampled at edge N puts the first coin valid in cycle N+1.
  - With ready tied high, a C-coin payout asserts o_done in cycle N+1+C.
- Width rules:
  - Coin values are zero-extended to TOTAL_BITS.
  - Subtraction cannot underflow, because the selected value is always <= residual.
- i_total is sampled only on ISSUE entry. Later changes to it during the return are ignored.

Decomposition:
- Shared definitions file holds:
  - NUM_COINS, TOTAL_BITS, WAIT_TIME.
  - The coin value constants.
  - State encodings IDLE/ISSUE/DONE.
- One sub-module, coin_greedy_select (combinational):
  - Inputs: residual.
  - Outputs: one-hot coin, coin value, found flag.
- Everything else stays in this module.

Test Plan:
1. i_total=1600, trigger, ready=1 → coins 3'b100, 3'b010, 3'b001 on 3 consecutive cycles. o_deduct=1000, 500, 100. o_done the next cycle; o_residual=0.
2. i_total=2700, trigger, ready=1 → 3'b100 ×2, 3'b010, 3'b001 ×2 (5 coins). o_deduct sum = 2700.
3. i_total=500, trigger, ready held 0 for 4 cycles then 1 → valid=1 and 3'b010 stable for 4 cycles with no deduct. Deduct 500 on the 5th cycle, then o_done.
4. WAIT_TIME=5, insert coin, i_total=500, then idle → o_wait_time 5,4,3,2,1,0. Coin 3'b010 becomes valid the cycle after 0 is observed.
5. i_total=150, trigger → one 3'b001 coin, o_done, o_residual=50. i_total=0 with trigger → no valid, o_wait_time=0.
6. Reset asserted during the 2nd coin of scenario 2 → next cycle: IDLE, valid=0, o_wait_time=WAIT_TIME, no o_done. Separately, coin insert and trigger in the same cycle → timer reloads and no return starts.
